// File: rtl/proc_trace_buffer_if.sv
// Trace-buffer bus: processor-side trace stream in, val/rdy head-of-queue out.
// The buffer uses the slave view; whoever drives traces and drains the queue uses master.
interface proc_trace_buffer_if #(
  parameter int SEQ_W = 16
);
  logic             trace_val;
  logic [31:0]      trace_addr;
  logic [31:0]      trace_data;
  logic             out_val;
  logic             out_rdy;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic [SEQ_W-1:0] out_seq;

  modport master (
    output trace_val, trace_addr, trace_data, out_rdy,
    input  out_val, out_addr, out_data, out_seq
  );

  modport slave (
    input  trace_val, trace_addr, trace_data, out_rdy,
    output out_val, out_addr, out_data, out_seq
  );
endinterface

// File: rtl/proc_trace_buffer.sv
// Retired-instruction trace FIFO: tags each trace with a sequence number, queues it,
// drains over val/rdy and counts entries dropped while full.
module proc_trace_buffer #(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  proc_trace_buffer_if.slave         bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [DROP_W-1:0]          drop_count,
  output logic                       overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [31:0]      mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [SEQ_W-1:0] mem_seq  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [SEQ_W-1:0]  seq_reg;
  logic [DROP_W-1:0] drop_reg;
  logic              overflow_reg;

  logic deq, enq, drop;

  // out_val comes only from registered occupancy, never from out_rdy.
  assign bus.out_val  = (count_reg != '0);
  assign bus.out_addr = mem_addr[rd_ptr_reg];
  assign bus.out_data = mem_data[rd_ptr_reg];
  assign bus.out_seq  = mem_seq[rd_ptr_reg];

  assign full       = (count_reg == DEPTH_C);
  assign count      = count_reg;
  assign drop_count = drop_reg;
  assign overflow   = overflow_reg;

  assign deq  = bus.out_val & bus.out_rdy;
  assign enq  = bus.trace_val & (!full | deq);
  assign drop = bus.trace_val & full & !deq;

  // Storage has no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq) begin
      mem_addr[wr_ptr_reg] <= bus.trace_addr;
      mem_data[wr_ptr_reg] <= bus.trace_data;
      mem_seq[wr_ptr_reg]  <= seq_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      seq_reg      <= '0;
      drop_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // Tags advance for every retired instruction, kept or not, so gaps stay visible.
      if (bus.trace_val) seq_reg <= seq_reg + 1'b1;

      if (flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        drop_reg     <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (enq && !deq)      count_reg <= count_reg + 1'b1;
        else if (deq && !enq) count_reg <= count_reg - 1'b1;
        if (drop) begin
          overflow_reg <= 1'b1;
          if (drop_reg != DROP_MAX) drop_reg <= drop_reg + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_proc_trace_buffer.sv
// Directed bench for proc_trace_buffer: default instance plus a 4-bit-tag instance for wraparound.
module tb_proc_trace_buffer;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [3:0]  count;
  logic        full;
  logic [7:0]  drop_count;
  logic        overflow;
  logic [3:0]  count4;
  logic        full4;
  logic [7:0]  drop_count4;
  logic        overflow4;

  int vec_cnt = 0;
  int err_cnt = 0;

  proc_trace_buffer_if #(.SEQ_W(16)) bus ();
  proc_trace_buffer_if #(.SEQ_W(4))  bus4 ();

  proc_trace_buffer #(.DEPTH(8), .SEQ_W(16), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .count(count), .full(full), .drop_count(drop_count), .overflow(overflow)
  );

  proc_trace_buffer #(.DEPTH(8), .SEQ_W(4), .DROP_W(8)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .flush(flush),
    .count(count4), .full(full4), .drop_count(drop_count4), .overflow(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.trace_val   = 1'b0;
    bus.trace_addr  = '0;
    bus.trace_data  = '0;
    bus.out_rdy     = 1'b0;
    bus4.trace_val  = 1'b0;
    bus4.trace_addr = '0;
    bus4.trace_data = '0;
    bus4.out_rdy    = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.trace_val  = 1'b1;
      bus.trace_addr = base + 32'(4 * i);
      bus.trace_data = 32'(i);
      cycle();
    end
    bus.trace_val = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vec_cnt++;
    if (bus.out_val !== 1'b0 || full !== 1'b0 || count !== 4'd0 ||
        drop_count !== 8'd0 || overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset: out_val=%b full=%b count=%0d drop=%0d ovf=%b required 0 0 0 0 0",
               bus.out_val, full, count, drop_count, overflow);
    end
    $display("reset: out_val=%b count=%0d", bus.out_val, count);
  endtask

  task automatic test_single();
    apply_reset();
    bus.trace_val  = 1'b1;
    bus.trace_addr = 32'h200;
    bus.trace_data = 32'h5;
    cycle();
    bus.trace_val = 1'b0;
    vec_cnt++;
    if (bus.out_val !== 1'b1 || bus.out_addr !== 32'h200 || bus.out_data !== 32'h5 ||
        bus.out_seq !== 16'd0 || count !== 4'd1) begin
      err_cnt++;
      $display("FAIL single_enq: val=%b addr=%h data=%h seq=%0d count=%0d required 1 00000200 00000005 0 1",
               bus.out_val, bus.out_addr, bus.out_data, bus.out_seq, count);
    end
    bus.out_rdy = 1'b1;
    cycle();
    bus.out_rdy = 1'b0;
    vec_cnt++;
    if (bus.out_val !== 1'b0 || count !== 4'd0) begin
      err_cnt++;
      $display("FAIL single_deq: val=%b count=%0d required 0 0", bus.out_val, count);
    end
    $display("single: enqueue/dequeue done");
  endtask

  task automatic test_empty_rdy();
    apply_reset();
    bus.out_rdy = 1'b1;
    cycle();
    cycle();
    bus.out_rdy = 1'b0;
    vec_cnt++;
    if (bus.out_val !== 1'b0 || count !== 4'd0) begin
      err_cnt++;
      $display("FAIL empty_rdy: val=%b count=%0d required 0 0", bus.out_val, count);
    end
    $display("empty_rdy: count=%0d", count);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.trace_val  = 1'b1;
      bus.trace_addr = 32'h200 + 32'(4 * i);
      bus.trace_data = 32'(i);
      cycle();
      vec_cnt++;
      if (bus.out_val !== 1'b1 || bus.out_seq !== 16'(i) ||
          bus.out_addr !== 32'h200 + 32'(4 * i) || count !== 4'd1 || drop_count !== 8'd0) begin
        err_cnt++;
        $display("FAIL stream[%0d]: val=%b seq=%0d addr=%h count=%0d drop=%0d required 1 %0d %h 1 0",
                 i, bus.out_val, bus.out_seq, bus.out_addr, count, drop_count,
                 i, 32'h200 + 32'(4 * i));
      end
    end
    bus.trace_val = 1'b0;
    cycle();
    bus.out_rdy = 1'b0;
    vec_cnt++;
    if (bus.out_val !== 1'b0 || count !== 4'd0) begin
      err_cnt++;
      $display("FAIL stream_end: val=%b count=%0d required 0 0", bus.out_val, count);
    end
    $display("back_to_back: 20 entries streamed");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      bus.trace_val  = 1'b1;
      bus.trace_addr = 32'h300 + 32'(4 * i);
      bus.trace_data = 32'(i);
      cycle();
      vec_cnt++;
      if (count !== 4'((i < 8) ? i + 1 : 8) || full !== ((i >= 7) ? 1'b1 : 1'b0)) begin
        err_cnt++;
        $display("FAIL fill[%0d]: count=%0d full=%b required %0d %b",
                 i, count, full, (i < 8) ? i + 1 : 8, (i >= 7));
      end
    end
    bus.trace_val = 1'b0;
    vec_cnt++;
    if (drop_count !== 8'd2 || overflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL overflow: drop=%0d ovf=%b required 2 1", drop_count, overflow);
    end
    bus.out_rdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      vec_cnt++;
      if (bus.out_val !== 1'b1 || bus.out_seq !== 16'(j) || bus.out_addr !== 32'h300 + 32'(4 * j)) begin
        err_cnt++;
        $display("FAIL drain[%0d]: val=%b seq=%0d addr=%h required 1 %0d %h",
                 j, bus.out_val, bus.out_seq, bus.out_addr, j, 32'h300 + 32'(4 * j));
      end
      cycle();
    end
    bus.out_rdy = 1'b0;
    vec_cnt++;
    if (bus.out_val !== 1'b0) begin
      err_cnt++;
      $display("FAIL drained_empty: val=%b required 0", bus.out_val);
    end
    push_n(1, 32'h400);
    vec_cnt++;
    if (bus.out_seq !== 16'd10 || drop_count !== 8'd2 || overflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL post_overflow: seq=%0d drop=%0d ovf=%b required 10 2 1",
               bus.out_seq, drop_count, overflow);
    end
    $display("overflow: drop=%0d ovf=%b", drop_count, overflow);
  endtask

  task automatic test_full_enq_deq();
    apply_reset();
    push_n(8, 32'h500);
    bus.trace_val  = 1'b1;
    bus.trace_addr = 32'h600;
    bus.out_rdy    = 1'b1;
    cycle();
    bus.trace_val = 1'b0;
    vec_cnt++;
    if (count !== 4'd8 || full !== 1'b1 || drop_count !== 8'd0 || bus.out_seq !== 16'd1) begin
      err_cnt++;
      $display("FAIL full_both: count=%0d full=%b drop=%0d head_seq=%0d required 8 1 0 1",
               count, full, drop_count, bus.out_seq);
    end
    for (int j = 1; j <= 8; j++) begin
      vec_cnt++;
      if (bus.out_seq !== 16'(j) ||
          bus.out_addr !== ((j == 8) ? 32'h600 : 32'h500 + 32'(4 * j))) begin
        err_cnt++;
        $display("FAIL full_order[%0d]: seq=%0d addr=%h required %0d %h", j, bus.out_seq,
                 bus.out_addr, j, (j == 8) ? 32'h600 : 32'h500 + 32'(4 * j));
      end
      cycle();
    end
    bus.out_rdy = 1'b0;
    $display("full_enq_deq: order preserved through simultaneous enq/deq");
  endtask

  task automatic test_flush();
    apply_reset();
    push_n(11, 32'h700);
    bus.out_rdy = 1'b1;
    cycle();
    cycle();
    cycle();
    bus.out_rdy = 1'b0;
    vec_cnt++;
    if (count !== 4'd5 || drop_count !== 8'd3 || overflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_flush: count=%0d drop=%0d ovf=%b required 5 3 1", count, drop_count, overflow);
    end
    flush          = 1'b1;
    bus.trace_val  = 1'b1;
    bus.trace_addr = 32'h800;
    bus.out_rdy    = 1'b1;
    cycle();
    flush         = 1'b0;
    bus.trace_val = 1'b0;
    bus.out_rdy   = 1'b0;
    vec_cnt++;
    if (count !== 4'd0 || bus.out_val !== 1'b0 || drop_count !== 8'd0 ||
        overflow !== 1'b0 || full !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush: count=%0d val=%b drop=%0d ovf=%b full=%b required 0 0 0 0 0",
               count, bus.out_val, drop_count, overflow, full);
    end
    push_n(1, 32'h900);
    vec_cnt++;
    if (bus.out_val !== 1'b1 || bus.out_seq !== 16'd12 || bus.out_addr !== 32'h900 || count !== 4'd1) begin
      err_cnt++;
      $display("FAIL post_flush: val=%b seq=%0d addr=%h count=%0d required 1 12 00000900 1",
               bus.out_val, bus.out_seq, bus.out_addr, count);
    end
    $display("flush: next seq=%0d", bus.out_seq);
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    bus4.out_rdy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus4.trace_val  = 1'b1;
      bus4.trace_addr = 32'h1000 + 32'(4 * i);
      cycle();
      vec_cnt++;
      if (bus4.out_val !== 1'b1 || bus4.out_seq !== 4'(i % 16)) begin
        err_cnt++;
        $display("FAIL wrap[%0d]: val=%b seq=%0d required 1 %0d", i, bus4.out_val, bus4.out_seq, i % 16);
      end
    end
    bus4.trace_val = 1'b0;
    cycle();
    bus4.out_rdy = 1'b0;
    $display("seq_wrap: 17 entries, tag wrapped");
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    push_n(3, 32'hA00);
    rst = 1'b1;
    bus.trace_val = 1'b1;
    flush = 1'b1;
    cycle();
    rst = 1'b0;
    flush = 1'b0;
    bus.trace_val = 1'b0;
    vec_cnt++;
    if (count !== 4'd0 || bus.out_val !== 1'b0 || drop_count !== 8'd0 || overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset: count=%0d val=%b drop=%0d ovf=%b required 0 0 0 0",
               count, bus.out_val, drop_count, overflow);
    end
    push_n(1, 32'hB00);
    vec_cnt++;
    if (bus.out_seq !== 16'd0 || bus.out_addr !== 32'hB00 || count !== 4'd1) begin
      err_cnt++;
      $display("FAIL mid_reset_seq: seq=%0d addr=%h count=%0d required 0 00000b00 1",
               bus.out_seq, bus.out_addr, count);
    end
    $display("reset_midstream: next seq=%0d", bus.out_seq);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_empty_rdy();
    test_back_to_back();
    test_overflow();
    test_full_enq_deq();
    test_flush();
    test_seq_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
